// File: rtl/iq_mixer_accum.sv
// iq_mixer_accum: IQ down-mixer with windowed integrate-and-dump accumulators.
//   CLK, RESET_N (async, active low), CE (sample enable)
//   ADC_VALUE, SIN_VALUE, COS_VALUE : aligned signed sample and DCO pair
//   PERIOD_IN, PERIOD_IN_WE         : window length shadow write (0 means 1)
//   I_OUT, Q_OUT                    : sums of ADC*COS / ADC*SIN over last window
//   OUT_VALID, OUT_ACK, OVERRUN     : result handshake and sticky overwrite flag
// Define IQ_MIXER_ACCUM_SATURATE_EN to clamp accumulators instead of wrapping.
module iq_mixer_accum #(
   parameter int ADC_WIDTH            = 12,
   parameter int SIN_TABLE_DATA_WIDTH = 13,
   parameter int ACC_WIDTH            = 48,
   parameter int PERIOD_BITS          = 16,
   parameter int DEFAULT_PERIOD       = 1024
) (
   input  logic                                   CLK,
   input  logic                                   RESET_N,
   input  logic                                   CE,
   input  logic signed [ADC_WIDTH-1:0]            ADC_VALUE,
   input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
   input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
   input  logic        [PERIOD_BITS-1:0]          PERIOD_IN,
   input  logic                                   PERIOD_IN_WE,
   output logic signed [ACC_WIDTH-1:0]            I_OUT,
   output logic signed [ACC_WIDTH-1:0]            Q_OUT,
   output logic                                   OUT_VALID,
   input  logic                                   OUT_ACK,
   output logic                                   OVERRUN
);
   localparam int PROD_W = ADC_WIDTH + SIN_TABLE_DATA_WIDTH;
   logic signed [ADC_WIDTH-1:0]            adc_q, adc_d;
   logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin_q, sin_d, cos_q, cos_d;
   logic                                   v1_q, v1_d, v2_q, v2_d;
   logic signed [PROD_W-1:0]               mul_ic_q, mul_ic_d, mul_qc_q, mul_qc_d;
   logic signed [ACC_WIDTH-1:0]            acc_ic_q, acc_ic_d, acc_qc_q, acc_qc_d;
   logic signed [ACC_WIDTH-1:0]            out_ic_q, out_ic_d, out_qc_q, out_qc_d;
   logic signed [ACC_WIDTH-1:0]            nxt_ic, nxt_qc;
   logic        [PERIOD_BITS-1:0]          cnt_q, cnt_d, period_q, period_d;
   logic                                   valid_q, valid_d, overrun_q, overrun_d;
   logic                                   acc_en, first, last, dump;
`ifdef IQ_MIXER_ACCUM_SATURATE_EN
   localparam int EXT_W = (ACC_WIDTH > PROD_W ? ACC_WIDTH : PROD_W) + 1;
   localparam logic signed [EXT_W-1:0] ACC_MAX = EXT_W'({1'b0, {(ACC_WIDTH-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] ACC_MIN = -ACC_MAX - EXT_W'(1);
   logic signed [EXT_W-1:0] sum_ic, sum_qc;
   logic                    sat_ic_q, sat_ic_d, sat_qc_q, sat_qc_d, hold_ic, hold_qc;
   function automatic logic signed [ACC_WIDTH-1:0] clamp(input logic signed [EXT_W-1:0] s);
      return s > ACC_MAX ? ACC_MAX[ACC_WIDTH-1:0] : s < ACC_MIN ? ACC_MIN[ACC_WIDTH-1:0] : s[ACC_WIDTH-1:0];
   endfunction
`endif
   always_comb begin
      adc_d    = CE ? ADC_VALUE : adc_q;
      sin_d    = CE ? SIN_VALUE : sin_q;
      cos_d    = CE ? COS_VALUE : cos_q;
      v1_d     = CE ? 1'b1 : v1_q;
      mul_ic_d = CE ? PROD_W'(adc_q) * PROD_W'(cos_q) : mul_ic_q;
      mul_qc_d = CE ? PROD_W'(adc_q) * PROD_W'(sin_q) : mul_qc_q;
      v2_d     = CE ? v1_q : v2_q;
      // The valid bits keep post-reset zeros in the pipeline out of the first window.
      acc_en   = CE && v2_q;
      // cnt_q == 0 means no window in progress: the next accumulated sample opens one
      // and takes its length from the shadow register at that moment.
      first    = cnt_q == '0;
      last     = first ? period_q == PERIOD_BITS'(1) : cnt_q == PERIOD_BITS'(1);
      dump     = acc_en && last;
      cnt_d    = !acc_en ? cnt_q : first ? period_q - PERIOD_BITS'(1) : cnt_q - PERIOD_BITS'(1);
`ifdef IQ_MIXER_ACCUM_SATURATE_EN
      // A clamped accumulator stays frozen until its window is dumped.
      sum_ic   = (first ? EXT_W'(0) : EXT_W'(acc_ic_q)) + EXT_W'(mul_ic_q);
      sum_qc   = (first ? EXT_W'(0) : EXT_W'(acc_qc_q)) + EXT_W'(mul_qc_q);
      hold_ic  = !first && sat_ic_q;
      hold_qc  = !first && sat_qc_q;
      nxt_ic   = hold_ic ? acc_ic_q : clamp(sum_ic);
      nxt_qc   = hold_qc ? acc_qc_q : clamp(sum_qc);
      sat_ic_d = acc_en ? hold_ic || sum_ic > ACC_MAX || sum_ic < ACC_MIN : sat_ic_q;
      sat_qc_d = acc_en ? hold_qc || sum_qc > ACC_MAX || sum_qc < ACC_MIN : sat_qc_q;
`else
      nxt_ic   = (first ? ACC_WIDTH'(0) : acc_ic_q) + ACC_WIDTH'(mul_ic_q);
      nxt_qc   = (first ? ACC_WIDTH'(0) : acc_qc_q) + ACC_WIDTH'(mul_qc_q);
`endif
      acc_ic_d  = acc_en ? nxt_ic : acc_ic_q;
      acc_qc_d  = acc_en ? nxt_qc : acc_qc_q;
      out_ic_d  = dump ? nxt_ic : out_ic_q;
      out_qc_d  = dump ? nxt_qc : out_qc_q;
      period_d  = PERIOD_IN_WE ? (PERIOD_IN == '0 ? PERIOD_BITS'(1) : PERIOD_IN) : period_q;
      valid_d   = dump || (valid_q && !OUT_ACK);
      overrun_d = dump && valid_q && !OUT_ACK ? 1'b1 : OUT_ACK ? 1'b0 : overrun_q;
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         adc_q     <= '0;
         sin_q     <= '0;
         cos_q     <= '0;
         v1_q      <= 1'b0;
         mul_ic_q  <= '0;
         mul_qc_q  <= '0;
         v2_q      <= 1'b0;
         acc_ic_q  <= '0;
         acc_qc_q  <= '0;
         out_ic_q  <= '0;
         out_qc_q  <= '0;
         cnt_q     <= '0;
         period_q  <= PERIOD_BITS'(DEFAULT_PERIOD);
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef IQ_MIXER_ACCUM_SATURATE_EN
         sat_ic_q  <= 1'b0;
         sat_qc_q  <= 1'b0;
`endif
      end else begin
         adc_q     <= adc_d;
         sin_q     <= sin_d;
         cos_q     <= cos_d;
         v1_q      <= v1_d;
         mul_ic_q  <= mul_ic_d;
         mul_qc_q  <= mul_qc_d;
         v2_q      <= v2_d;
         acc_ic_q  <= acc_ic_d;
         acc_qc_q  <= acc_qc_d;
         out_ic_q  <= out_ic_d;
         out_qc_q  <= out_qc_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
`ifdef IQ_MIXER_ACCUM_SATURATE_EN
         sat_ic_q  <= sat_ic_d;
         sat_qc_q  <= sat_qc_d;
`endif
      end
   end
   assign I_OUT     = out_ic_q;
   assign Q_OUT     = out_qc_q;
   assign OUT_VALID = valid_q;
   assign OVERRUN   = overrun_q;
endmodule

// File: tb/tb_iq_mixer_accum.sv
// tb_iq_mixer_accum: randomized and directed checks of iq_mixer_accum against a window-level model.
module tb_iq_mixer_accum;
   logic               CLK = 1'b0, RESET_N = 1'b0, CE = 1'b0, PERIOD_IN_WE = 1'b0, OUT_ACK = 1'b0;
   logic signed [11:0] ADC_VALUE = '0;
   logic signed [12:0] SIN_VALUE = '0, COS_VALUE = '0;
   logic        [15:0] PERIOD_IN = '0;
   logic signed [47:0] I_OUT, Q_OUT;
   logic               OUT_VALID, OVERRUN;
   logic signed [11:0] w_adc = 12'h800;
   logic signed [12:0] w_dco = 13'h1000;
   logic signed [23:0] w_i, w_q;
   logic               w_valid, w_ovr;
`ifdef IQ_MIXER_ACCUM_SATURATE_EN
   localparam longint W24_EXP = 8388607;
`else
   localparam longint W24_EXP = -8388608;
`endif
   int     checks = 0, errors = 0, lat;
   longint pipe_i[$], pipe_q[$];
   longint win_i, win_q, exp_i, exp_q;
   int     win_n, win_len, shadow;
   logic   exp_v, exp_o;

   iq_mixer_accum dut (
      .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .ADC_VALUE(ADC_VALUE), .SIN_VALUE(SIN_VALUE),
      .COS_VALUE(COS_VALUE), .PERIOD_IN(PERIOD_IN), .PERIOD_IN_WE(PERIOD_IN_WE), .I_OUT(I_OUT),
      .Q_OUT(Q_OUT), .OUT_VALID(OUT_VALID), .OUT_ACK(OUT_ACK), .OVERRUN(OVERRUN));

   iq_mixer_accum #(.ACC_WIDTH(24)) w24 (
      .CLK(CLK), .RESET_N(RESET_N), .CE(1'b1), .ADC_VALUE(w_adc), .SIN_VALUE(w_dco),
      .COS_VALUE(w_dco), .PERIOD_IN(16'd1), .PERIOD_IN_WE(1'b1), .I_OUT(w_i),
      .Q_OUT(w_q), .OUT_VALID(w_valid), .OUT_ACK(1'b1), .OVERRUN(w_ovr));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pipe_i.delete();
      pipe_q.delete();
      win_i = 0; win_q = 0; win_n = 0; win_len = 0;
      exp_i = 0; exp_q = 0; exp_v = 1'b0; exp_o = 1'b0;
      shadow = 1024;
   endtask

   // A CE sample is accumulated two CE edges after it is presented; a window closes
   // once it holds the number of samples the shadow length had when it opened.
   task automatic model_edge();
      logic   dump;
      longint pi, pq;
      dump = 1'b0;
      if (CE) begin
         if (pipe_i.size() == 2) begin
            pi = pipe_i.pop_front();
            pq = pipe_q.pop_front();
            if (win_n == 0) win_len = shadow;
            win_i += pi;
            win_q += pq;
            win_n++;
            if (win_n == win_len) begin
               dump = 1'b1;
               exp_i = win_i; exp_q = win_q;
               win_i = 0; win_q = 0; win_n = 0;
            end
         end
         pipe_i.push_back(longint'(ADC_VALUE) * longint'(COS_VALUE));
         pipe_q.push_back(longint'(ADC_VALUE) * longint'(SIN_VALUE));
      end
      exp_o = (dump && exp_v && !OUT_ACK) ? 1'b1 : OUT_ACK ? 1'b0 : exp_o;
      exp_v = dump || (exp_v && !OUT_ACK);
      if (PERIOD_IN_WE) shadow = (PERIOD_IN == 0) ? 1 : int'(PERIOD_IN);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      chk("i_out", I_OUT, exp_i);
      chk("q_out", Q_OUT, exp_q);
      chk("out_valid", OUT_VALID, exp_v);
      chk("overrun", OVERRUN, exp_o);
   endtask

   task automatic rnd();
      ADC_VALUE = 12'($urandom);
      SIN_VALUE = 13'($urandom);
      COS_VALUE = 13'($urandom);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_i", I_OUT, 0);
      chk("reset_q", Q_OUT, 0);
      chk("reset_valid", OUT_VALID, 0);
      chk("reset_overrun", OVERRUN, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      // constant tone, 4-sample windows
      PERIOD_IN = 16'd4; PERIOD_IN_WE = 1'b1;
      tick();
      PERIOD_IN_WE = 1'b0;
      ADC_VALUE = 12'sd100; SIN_VALUE = 13'sd4095; COS_VALUE = 13'sd0; CE = 1'b1;
      lat = 0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (lat == 0 && OUT_VALID) lat = k;
         if (k == 6 || k == 10 || k == 14) begin
            chk("tone_q", Q_OUT, 1638000);
            chk("tone_i", I_OUT, 0);
         end
      end
      chk("tone_latency", lat, 6);
      chk("w24_q", w_q, W24_EXP);
      chk("w24_i", w_i, W24_EXP);
      chk("w24_valid", w_valid, 1);
      chk("w24_overrun", w_ovr, 0);
      OUT_ACK = 1'b1; CE = 1'b0;
      tick();
      OUT_ACK = 1'b0;
      // CE gaps inside windows
      for (int k = 0; k < 16; k++) begin
         CE = (k % 2 == 0);
         rnd();
         tick();
      end
      // shortened window length written mid-window
      CE = 1'b1;
      rnd(); tick();
      rnd(); tick();
      PERIOD_IN = 16'd2; PERIOD_IN_WE = 1'b1;
      rnd(); tick();
      PERIOD_IN_WE = 1'b0;
      for (int k = 0; k < 12; k++) begin rnd(); tick(); end
      // handshake: overwrite, acknowledge, acknowledge coincident with a dump
      OUT_ACK = 1'b1; CE = 1'b0;
      tick();
      chk("ack_clear_valid", OUT_VALID, 0);
      OUT_ACK = 1'b0; CE = 1'b1;
      for (int k = 0; k < 5; k++) begin rnd(); tick(); end
      chk("overwrite_overrun", OVERRUN, 1);
      chk("overwrite_valid", OUT_VALID, 1);
      OUT_ACK = 1'b1; CE = 1'b0;
      tick();
      chk("ack_valid", OUT_VALID, 0);
      chk("ack_overrun", OVERRUN, 0);
      OUT_ACK = 1'b0; CE = 1'b1;
      for (int k = 0; k < 4 && !OUT_VALID; k++) begin rnd(); tick(); end
      chk("dump_seen", OUT_VALID, 1);
      rnd(); tick();
      OUT_ACK = 1'b1;
      rnd(); tick();
      chk("coincident_valid", OUT_VALID, 1);
      chk("coincident_overrun", OVERRUN, 0);
      OUT_ACK = 1'b0;
      // random traffic
      for (int k = 0; k < 300; k++) begin
         CE = ($urandom_range(0, 9) < 7);
         OUT_ACK = ($urandom_range(0, 9) < 3);
         PERIOD_IN_WE = ($urandom_range(0, 19) == 0);
         PERIOD_IN = 16'($urandom_range(0, 5));
         rnd();
         tick();
      end
      PERIOD_IN_WE = 1'b0; OUT_ACK = 1'b0; CE = 1'b1;
      for (int k = 0; k < 3; k++) begin rnd(); tick(); end
      // asynchronous reset pulse mid-window
      #1 RESET_N = 1'b0;
      #1;
      chk("async_i", I_OUT, 0);
      chk("async_q", Q_OUT, 0);
      chk("async_valid", OUT_VALID, 0);
      chk("async_overrun", OVERRUN, 0);
      model_reset();
      RESET_N = 1'b1;
      lat = 0;
      for (int k = 1; k <= 1100 && lat == 0; k++) begin
         rnd();
         tick();
         if (OUT_VALID) lat = k;
      end
      chk("default_window_latency", lat, 1026);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/iq_mixer_accum.md
IQ_MIXER_ACCUM -- requirements
Module: iq_mixer_accum

Interface
REQ-001 The block SHALL have parameter ADC_WIDTH, default 12, meaning the signed ADC sample width.
REQ-002 The block SHALL have parameter SIN_TABLE_DATA_WIDTH, default 13, meaning the signed DCO SIN/COS width.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 48, meaning the signed accumulator and output width.
REQ-004 The block SHALL have parameter PERIOD_BITS, default 16, meaning the window length register width.
REQ-005 The block SHALL have parameter DEFAULT_PERIOD, default 1024, meaning the window length after reset.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous active-low reset.
- CE  in  1  sample enable; 1 = inputs form a valid sample, 0 = pipeline and counter hold.
- ADC_VALUE  in  ADC_WIDTH  signed input sample.
- SIN_VALUE  in  SIN_TABLE_DATA_WIDTH  signed DCO sine, aligned with ADC_VALUE.
- COS_VALUE  in  SIN_TABLE_DATA_WIDTH  signed DCO cosine, aligned with ADC_VALUE.
- PERIOD_IN  in  PERIOD_BITS  new window length in samples.
- PERIOD_IN_WE  in  1  write strobe for PERIOD_IN.
- I_OUT  out  ACC_WIDTH  signed sum of ADC*COS over the last completed window.
- Q_OUT  out  ACC_WIDTH  signed sum of ADC*SIN over the last completed window.
- OUT_VALID  out  1  result pending.
- OUT_ACK  in  1  consumer acknowledge.
- OVERRUN  out  1  sticky flag: a result was overwritten before it was acknowledged.

Function
REQ-007 The datapath SHALL be 3 stages: input register, then full-precision signed multiply (ADC_WIDTH+SIN_TABLE_DATA_WIDTH bits), then sign-extended accumulate; every stage advances only when CE=1.
REQ-008 A sample presented with CE=1 on edge n SHALL enter the accumulators on the second following CE=1 edge.
REQ-009 A window SHALL be exactly the active period length of consecutive accumulated samples, counted at the accumulate stage by a down-counter.
REQ-010 On the accumulate edge of the last sample of a window, the final sums (including that sample) SHALL be copied to I_OUT/Q_OUT, and OUT_VALID SHALL be set on the same edge.
REQ-011 On that same edge the accumulators SHALL be loaded with the next product, not cleared then added, so that no sample is dropped between windows.
REQ-012 A PERIOD_IN_WE=1 edge SHALL latch PERIOD_IN into a shadow register; the shadow value SHALL become active at the next window boundary.
REQ-013 A latched PERIOD_IN of 0 SHALL be treated as 1.
REQ-014 OUT_VALID SHALL stay high until an edge with OUT_ACK=1 and no new dump on that edge; OUT_ACK is honoured regardless of CE.
REQ-015 A dump while OUT_VALID=1 and OUT_ACK=0 SHALL overwrite I_OUT/Q_OUT, keep OUT_VALID=1 and set OVERRUN.
REQ-016 A dump on the same edge as OUT_ACK=1 SHALL leave OUT_VALID=1 with the new data and SHALL NOT set OVERRUN.
REQ-017 OVERRUN SHALL clear only on an OUT_ACK=1 edge without a simultaneous overrun.
REQ-018 Without saturation (see Configuration), accumulator overflow SHALL wrap two's-complement.

Reset
REQ-019 RESET_N=0 SHALL asynchronously clear all of the following: pipeline registers, accumulators, I_OUT, Q_OUT, OUT_VALID and OVERRUN.
REQ-020 RESET_N=0 SHALL also load the active and shadow period with DEFAULT_PERIOD and restart the window counter.
REQ-021 Reset asserted mid-window SHALL discard the partial sums; the first window after release SHALL start with the first CE=1 sample reaching the accumulate stage.

Configuration
REQ-022 With macro IQ_MIXER_ACCUM_SATURATE_EN defined, each accumulator SHALL clamp to the most-positive or most-negative ACC_WIDTH value instead of wrapping, and the clamp SHALL persist until the window dump.
REQ-023 Without IQ_MIXER_ACCUM_SATURATE_EN, accumulators SHALL wrap and no clamp logic SHALL be present.

Verification
REQ-024 The bench SHALL cover these scenarios:
- ADC=100, SIN=4095, COS=0 constant, PERIOD_IN=4, CE=1 -> OUT_VALID rises 5 edges after the first sample; I_OUT=0, Q_OUT=1638000; repeats every 4 edges.
- ADC=-2048, SIN=COS=-4096, PERIOD=1, ACC_WIDTH=24 -> without the macro Q_OUT=8388608 wraps to -8388608; with the macro it clamps to 8388607.
- CE toggled 1,0,1,0 during a PERIOD=4 window -> dump after exactly 4 CE=1 samples; sums equal the 4-sample reference.
- PERIOD_IN=2 written mid-window of length 4 -> the current window completes at 4 samples, subsequent windows are 2 samples.
- OUT_ACK held 0 across two dumps -> second result visible, OVERRUN=1; OUT_ACK pulse -> OUT_VALID=0, OVERRUN=0; OUT_ACK coincident with a dump -> OUT_VALID stays 1, OVERRUN stays 0.
- RESET_N pulsed low for 1 ns mid-window -> all outputs 0 immediately; next window is a full DEFAULT_PERIOD samples.
